// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel/sync bus types and the RGB332 -> 4:4:4 DAC expansion.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIPE_DLY = 2;
    localparam logic        DEF_SYNC_POL = 1'b0;

    typedef logic [7:0] rgb332_t;

    // Sync fields are kept in raw (asserted = 1) sense; polarity is applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_bus_t;

    localparam sync_bus_t SYNC_IDLE = '0;

    // Replicate the high bits so full-scale 3/2-bit inputs map to full-scale 4-bit outputs.
    function automatic logic [11:0] rgb332_to_444(input rgb332_t c);
        return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for the raw sync/active bus, matching the drawing-path latency.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_PIPE_DLY
) (
    input  logic      clk,
    input  logic      reset,
    input  sync_bus_t din,
    output sync_bus_t dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
            assign dout = din;
        end else begin : g_shift
            sync_bus_t stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= SYNC_IDLE;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counter with sync/blank generation, latency-matched to the drawing path,
// and registered RGB332 -> 4:4:4 DAC outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PIPE_DLY = DEF_PIPE_DLY,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [7:0]  drawing_RGB,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic      x_last;
    logic      y_last;
    sync_bus_t sync_raw;
    sync_bus_t sync_dly;
    logic [11:0] rgb444;

    assign x_last = (pixelX == H_LAST);
    assign y_last = (pixelY == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelX <= '0;
            pixelY <= '0;
        end else if (pix_en) begin
            if (x_last) begin
                pixelX <= '0;
                pixelY <= y_last ? '0 : pixelY + 11'd1;
            end else begin
                pixelX <= pixelX + 11'd1;
            end
        end
    end

    assign startOfFrame = pix_en & x_last & y_last;

    always_comb begin
        sync_raw     = SYNC_IDLE;
        sync_raw.hs  = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
        sync_raw.vs  = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);
        sync_raw.act = (pixelX < H_VIS) && (pixelY < V_VIS);
    end

    vga_sync_delay #(
        .DEPTH (PIPE_DLY)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (sync_raw),
        .dout  (sync_dly)
    );

    assign rgb444 = rgb332_to_444(drawing_RGB);

    // drawing_RGB already carries PIPE_DLY clks of latency, so it pairs with sync_dly here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
            blank_n <= 1'b0;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else begin
            hsync   <= sync_dly.hs ? SYNC_POL : ~SYNC_POL;
            vsync   <= sync_dly.vs ? SYNC_POL : ~SYNC_POL;
            blank_n <= sync_dly.act;
            {vga_r, vga_g, vga_b} <= sync_dly.act ? rgb444 : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three timing generators (default, small PIPE_DLY=0 active-high, small PIPE_DLY=3)
// driven by shared random stimulus and checked against a pixel-index based reference model.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int HA  [NI] = '{640, 20, 24};
    localparam int HF  [NI] = '{16, 4, 3};
    localparam int HS  [NI] = '{96, 6, 5};
    localparam int HB  [NI] = '{48, 5, 4};
    localparam int VA  [NI] = '{480, 12, 10};
    localparam int VF  [NI] = '{10, 2, 3};
    localparam int VS  [NI] = '{2, 3, 2};
    localparam int VB  [NI] = '{33, 4, 5};
    localparam int DLY [NI] = '{2, 0, 3};
    localparam int POL [NI] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [7:0]  drawing_RGB;
    logic [10:0] px [NI];
    logic [10:0] py [NI];
    logic        sof [NI];
    logic        hs_o [NI];
    logic        vs_o [NI];
    logic        bl_o [NI];
    logic [3:0]  vr [NI];
    logic [3:0]  vg [NI];
    logic [3:0]  vb [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE (HA[gi]),
            .H_FP     (HF[gi]),
            .H_SYNC   (HS[gi]),
            .H_BP     (HB[gi]),
            .V_ACTIVE (VA[gi]),
            .V_FP     (VF[gi]),
            .V_SYNC   (VS[gi]),
            .V_BP     (VB[gi]),
            .PIPE_DLY (DLY[gi]),
            .SYNC_POL (1'(POL[gi]))
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .pix_en       (pix_en),
            .drawing_RGB  (drawing_RGB),
            .pixelX       (px[gi]),
            .pixelY       (py[gi]),
            .startOfFrame (sof[gi]),
            .hsync        (hs_o[gi]),
            .vsync        (vs_o[gi]),
            .blank_n      (bl_o[gi]),
            .vga_r        (vr[gi]),
            .vga_g        (vg[gi]),
            .vga_b        (vb[gi])
        );
    end

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } exp_t;
    typedef exp_t [NI-1:0] exp3_t;

    exp3_t      sbq [$];
    exp_t       nxt [NI];
    logic [2:0] hist [NI][8];
    int         n = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         done = 0;
    bit         started = 0;

    function automatic exp_t idle_pins(int i);
        exp_t e;
        e    = '0;
        e.hs = (POL[i] == 0);
        e.vs = (POL[i] == 0);
        return e;
    endfunction

    function automatic logic [3:0] ex3(logic [2:0] v);
        int t;
        t = int'(v);
        return 4'(t * 2 + t / 4);
    endfunction

    task automatic chk(int i, string nm, int got, int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, i, cyc, got, expv);
        end
    endtask

    // One clk of stimulus; the model tracks a linear pixel index and derives everything from it.
    task automatic step(bit r, bit pe, logic [7:0] rgb);
        exp3_t      e;
        int         x, y, ht, vt;
        logic       rh, rv, ra;
        logic [2:0] d;
        @(negedge clk);
        reset = r;
        pix_en = pe;
        drawing_RGB = rgb;
        cyc++;
        started = 1;
        for (int i = 0; i < NI; i++) begin
            ht = HA[i] + HF[i] + HS[i] + HB[i];
            vt = VA[i] + VF[i] + VS[i] + VB[i];
            if (r) begin
                e[i] = idle_pins(i);
                for (int j = 0; j < 8; j++) hist[i][j] = '0;
                nxt[i] = idle_pins(i);
            end else begin
                x = n % ht;
                y = (n / ht) % vt;
                e[i]     = nxt[i];
                e[i].x   = 11'(x);
                e[i].y   = 11'(y);
                e[i].sof = pe && (x == ht - 1) && (y == vt - 1);
                rh = (x >= HA[i] + HF[i]) && (x < HA[i] + HF[i] + HS[i]);
                rv = (y >= VA[i] + VF[i]) && (y < VA[i] + VF[i] + VS[i]);
                ra = (x < HA[i]) && (y < VA[i]);
                for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = {rh, rv, ra};
                d = hist[i][DLY[i]];
                nxt[i]    = idle_pins(i);
                nxt[i].hs = d[2] ? (POL[i] != 0) : (POL[i] == 0);
                nxt[i].vs = d[1] ? (POL[i] != 0) : (POL[i] == 0);
                nxt[i].bl = d[0];
                if (d[0]) begin
                    nxt[i].r = ex3(rgb[7:5]);
                    nxt[i].g = ex3(rgb[4:2]);
                    nxt[i].b = 4'(int'(rgb[1:0]) * 5);
                end
            end
        end
        sbq.push_back(e);
        if (r) n = 0;
        else   n += int'(pe);
    endtask

    initial begin : monitor
        exp3_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (sbq.size() == 0) begin
                if (started) chk(0, "scoreboard_empty", 0, 1);
                continue;
            end
            e = sbq.pop_front();
            for (int i = 0; i < NI; i++) begin
                chk(i, "pixelX",       int'(px[i]),   int'(e[i].x));
                chk(i, "pixelY",       int'(py[i]),   int'(e[i].y));
                chk(i, "startOfFrame", int'(sof[i]),  int'(e[i].sof));
                chk(i, "hsync",        int'(hs_o[i]), int'(e[i].hs));
                chk(i, "vsync",        int'(vs_o[i]), int'(e[i].vs));
                chk(i, "blank_n",      int'(bl_o[i]), int'(e[i].bl));
                chk(i, "vga_r",        int'(vr[i]),   int'(e[i].r));
                chk(i, "vga_g",        int'(vg[i]),   int'(e[i].g));
                chk(i, "vga_b",        int'(vb[i]),   int'(e[i].b));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int guard;
        reset = 1'b1;
        pix_en = 1'b0;
        drawing_RGB = '0;
        repeat (3)    step(1, 0, 8'($urandom));
        repeat (2000) step(0, 1, 8'($urandom));
        repeat (900)  step(0, 1, 8'hFF);
        repeat (300)  step(0, 1, 8'b101_010_01);
        repeat (3000) step(0, 1'($urandom_range(0, 1)), 8'($urandom));
        for (int k = 0; k < 1000; k++) step(0, (k % 2) == 0, 8'($urandom));
        // Park the default-geometry generator inside its hsync pulse before a mid-line reset.
        guard = 0;
        while ((n % 800) != 700 && guard < 1000) begin
            step(0, 1, 8'($urandom));
            guard++;
        end
        repeat (3)    step(1, 1'($urandom_range(0, 1)), 8'($urandom));
        repeat (1500) step(0, 1, 8'($urandom));
        repeat (300)  step(0, 1'($urandom_range(0, 1)), 8'($urandom));
        @(negedge clk);
        done = 1;
        #5;
        if (sbq.size() != 0) chk(0, "scoreboard_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
